// File: rtl/udt_ctrl_tx.sv
// UDT control-packet transmitter: queues ACK/ACK2 (and optional keep-alive) requests
// and serialises them as 64-bit words. Optional feature macro: UDT_KEEPALIVE_EN.
module udt_ctrl_tx #(
  parameter int unsigned CLK_PER_US = 156,
  parameter logic [31:0] KA_CYCLES  = 32'd156_250_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dst_sock_id,
  input  logic        ack_req,
  input  logic [31:0] ack_num,
  input  logic [31:0] ack_rcv_seq,
  input  logic        ack2_req,
  input  logic [31:0] ack2_num,
  output logic [63:0] tx_data,
  output logic [7:0]  tx_keep,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic [15:0] ovf_cnt
);

  typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;

  localparam logic [14:0] T_KA   = 15'd1;
  localparam logic [14:0] T_ACK  = 15'd2;
  localparam logic [14:0] T_ACK2 = 15'd6;

  state_t      r_state;
  logic        r_pend_ack, r_pend_ack2;
  logic [31:0] r_ack_num, r_ack_seq, r_ack2_num;
  logic [31:0] r_presc, r_ts;
  logic [14:0] r_type;
  logic [31:0] r_snap_seq, r_snap_ts;
  logic [63:0] r_tx_data;
  logic [7:0]  r_tx_keep;
  logic        r_tx_valid, r_tx_last;
  logic [15:0] r_ovf;

  logic        w_pend_ka;
  logic        w_start, w_sel_ack, w_sel_ack2;
  logic [14:0] w_type;
  logic [31:0] w_info;
  logic        w_ovf_a, w_ovf_2;
  logic [16:0] w_ovf_sum;

  assign tx_data  = r_tx_data;
  assign tx_keep  = r_tx_keep;
  assign tx_valid = r_tx_valid;
  assign tx_last  = r_tx_last;
  assign ovf_cnt  = r_ovf;

  assign w_start    = (r_state == IDLE) && (r_pend_ack2 || r_pend_ack || w_pend_ka);
  assign w_sel_ack2 = w_start && r_pend_ack2;
  assign w_sel_ack  = w_start && !r_pend_ack2 && r_pend_ack;

  always_comb begin
    w_type = T_KA;
    w_info = '0;
    if (r_pend_ack2) begin
      w_type = T_ACK2;
      w_info = r_ack2_num;
    end else if (r_pend_ack) begin
      w_type = T_ACK;
      w_info = r_ack_num;
    end
  end

  // A request landing on the selection edge re-arms the flag with the new fields
  // while the snapshot takes the old ones, so it is not an overflow.
  assign w_ovf_a   = ack_req  && r_pend_ack  && !w_sel_ack;
  assign w_ovf_2   = ack2_req && r_pend_ack2 && !w_sel_ack2;
  assign w_ovf_sum = {1'b0, r_ovf} + {16'b0, w_ovf_a} + {16'b0, w_ovf_2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_ack  <= 1'b0;
      r_pend_ack2 <= 1'b0;
      r_ack_num   <= '0;
      r_ack_seq   <= '0;
      r_ack2_num  <= '0;
      r_ovf       <= '0;
    end else begin
      if (ack_req) begin
        r_pend_ack <= 1'b1;
        r_ack_num  <= ack_num;
        r_ack_seq  <= ack_rcv_seq;
      end else if (w_sel_ack) begin
        r_pend_ack <= 1'b0;
      end
      if (ack2_req) begin
        r_pend_ack2 <= 1'b1;
        r_ack2_num  <= ack2_num;
      end else if (w_sel_ack2) begin
        r_pend_ack2 <= 1'b0;
      end
      r_ovf <= w_ovf_sum[16] ? '1 : w_ovf_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_ts    <= '0;
    end else if (r_presc == CLK_PER_US - 32'd1) begin
      r_presc <= '0;
      r_ts    <= r_ts + 32'd1;
    end else begin
      r_presc <= r_presc + 32'd1;
    end
  end

`ifdef UDT_KEEPALIVE_EN
  logic        r_pend_ka;
  logic [31:0] r_idle;
  logic        w_hs_last, w_ka_fire, w_sel_ka;

  assign w_pend_ka = r_pend_ka;
  assign w_hs_last = r_tx_valid && tx_ready && r_tx_last;
  assign w_ka_fire = !w_hs_last && (r_idle == KA_CYCLES - 32'd1);
  assign w_sel_ka  = w_start && !r_pend_ack2 && !r_pend_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle    <= '0;
      r_pend_ka <= 1'b0;
    end else begin
      if (w_hs_last || w_ka_fire) r_idle <= '0;
      else                        r_idle <= r_idle + 32'd1;
      if (w_ka_fire)     r_pend_ka <= 1'b1;
      else if (w_sel_ka) r_pend_ka <= 1'b0;
    end
  end
`else
  logic [31:0] w_unused_ka;
  assign w_unused_ka = KA_CYCLES;
  assign w_pend_ka   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_type     <= '0;
      r_snap_seq <= '0;
      r_snap_ts  <= '0;
      r_tx_data  <= '0;
      r_tx_keep  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state    <= W0;
            r_type     <= w_type;
            r_snap_seq <= r_ack_seq;
            r_snap_ts  <= r_ts;
            r_tx_data  <= {1'b1, w_type, 16'h0000, w_info};
            r_tx_keep  <= 8'hFF;
            r_tx_valid <= 1'b1;
            r_tx_last  <= 1'b0;
          end
        end
        W0: begin
          if (tx_ready) begin
            r_state   <= W1;
            r_tx_data <= {r_snap_ts, dst_sock_id};
            r_tx_last <= (r_type != T_ACK);
          end
        end
        W1: begin
          if (tx_ready) begin
            if (r_type == T_ACK) begin
              r_state   <= W2;
              r_tx_data <= {r_snap_seq, 32'h0000_0000};
              r_tx_keep <= 8'hF0;
              r_tx_last <= 1'b1;
            end else begin
              r_state    <= IDLE;
              r_tx_data  <= '0;
              r_tx_keep  <= '0;
              r_tx_valid <= 1'b0;
              r_tx_last  <= 1'b0;
            end
          end
        end
        W2: begin
          if (tx_ready) begin
            r_state    <= IDLE;
            r_tx_data  <= '0;
            r_tx_keep  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/udt_ctrl_tx.md
UDT_CTRL_TX -- requirements
Module: udt_ctrl_tx

Interface
REQ-001 The block SHALL have parameter CLK_PER_US, default 156, giving clk cycles per microsecond for the timestamp prescaler.
REQ-002 The block SHALL have parameter KA_CYCLES, default 32'd156_250_000, giving idle cycles before a keep-alive is generated.
REQ-003 Ports SHALL be:
clk  in  1  single clock for all logic.
rst_n  in  1  asynchronous active-low reset.
dst_sock_id  in  32  destination socket ID; static while out of reset.
ack_req  in  1  one-cycle pulse requesting an ACK.
ack_num  in  32  ACK sequence number; sampled with ack_req.
ack_rcv_seq  in  32  received data sequence number; sampled with ack_req.
ack2_req  in  1  one-cycle pulse requesting an ACK2.
ack2_num  in  32  ACK2 sequence number; sampled with ack2_req.
tx_data  out  64  packet word, big-endian, byte 0 in [63:56].
tx_keep  out  8  byte enables, MSB is byte 0.
tx_valid  out  1  word valid.
tx_last  out  1  last word of packet.
tx_ready  in  1  downstream accept.
ovf_cnt  out  16  saturating count of overwritten pending requests.

Function
REQ-004 A request pulse sampled at edge k SHALL set that type's pending flag and field register at edge k, with the new fields overwriting any older ones.
REQ-005 If a request arrives while its pending flag is set and that flag is not being cleared in the same cycle, ovf_cnt SHALL increment, saturating at 16'hFFFF.
REQ-006 If a request arrives in the same cycle its pending flag is cleared by selection, the flag SHALL remain set with the new fields, and ovf_cnt SHALL NOT increment.
REQ-007 The FSM SHALL have the states IDLE, W0, W1 and W2.
REQ-008 In IDLE with any pending flag set, the FSM SHALL select by priority ACK2 > ACK > keep-alive, snapshot the fields and timestamp, clear the selected flag, and enter W0 at the next edge.
REQ-009 A pulse sampled at edge k SHALL produce tx_valid high after edge k+1, provided the FSM is in IDLE with no higher-priority pending request.
REQ-010 W0 SHALL output tx_data = {1'b1, type[14:0], 16'h0000, add_info[31:0]} with tx_keep = 8'hFF.
REQ-011 Packet types SHALL be: keep-alive 15'd1 with add_info 0; ACK 15'd2 with add_info = ack_num; ACK2 15'd6 with add_info = ack2_num.
REQ-012 W1 SHALL output {timestamp[31:0], dst_sock_id[31:0]} with tx_keep = 8'hFF.
REQ-013 W1 SHALL assert tx_last for ACK2 and keep-alive packets.
REQ-014 W2 (ACK only) SHALL output {ack_rcv_seq, 32'h0} with tx_keep = 8'hF0 and tx_last = 1.
REQ-015 A state SHALL advance only on tx_valid && tx_ready.
REQ-016 tx_data, tx_keep and tx_last SHALL hold stable while tx_valid && !tx_ready.
REQ-017 On acceptance of the last word the FSM SHALL return to IDLE, and tx_valid SHALL deassert for at least one cycle between packets.
REQ-018 The timestamp SHALL be a free-running microsecond counter: the prescaler counts 0..CLK_PER_US-1, and the 32-bit counter increments on prescaler wrap and wraps 32'hFFFFFFFF to 0.
REQ-019 Request pulses SHALL be captured regardless of FSM state or tx_ready stall.

Reset
REQ-020 On rst_n low, asynchronously: state=IDLE; all pending flags, field registers, timestamp, prescaler, idle counter and ovf_cnt = 0; tx_valid=0, tx_last=0, tx_keep=0, tx_data=0.
REQ-021 Reset asserted mid-packet SHALL abort the packet immediately, and no partial packet SHALL resume after release.
REQ-022 Requests pulsed during reset SHALL be discarded.

Configuration
REQ-023 With UDT_KEEPALIVE_EN defined, an idle counter SHALL count cycles since the last tx_last handshake, reset on each such handshake.
REQ-024 With UDT_KEEPALIVE_EN defined, the idle counter reaching KA_CYCLES-1 SHALL set the keep-alive pending flag and restart the counter.
REQ-025 Without UDT_KEEPALIVE_EN, the keep-alive logic SHALL be absent, and type 1 SHALL never be emitted.

Verification
REQ-026 ACK2 pulse with ack2_num=32'h0000_0005, dst_sock_id=32'hCAFE_0001, tx_ready=1 -> two words: 64'h8006_0000_0000_0005, then {ts, 32'hCAFE_0001} with tx_last=1; tx_valid first high 2 edges after pulse.
REQ-027 ACK pulse with ack_num=7, ack_rcv_seq=32'h1234_5678 -> words 64'h8002_0000_0000_0007, {ts, sock}, 64'h1234_5678_0000_0000 with keep 8'hF0 and last=1.
REQ-028 ACK and ACK2 pulsed in the same cycle -> complete ACK2 packet, idle cycle, then complete ACK packet; ovf_cnt=0.
REQ-029 tx_ready held low 10 cycles during W1 -> tx_data constant for all 10 cycles; two ACK pulses during the stall with ack_num 1 then 2 -> next ACK carries 2, ovf_cnt=1.
REQ-030 rst_n dropped during W1 of an ACK -> tx_valid=0 immediately; after release no output until a new request.
REQ-031 UDT_KEEPALIVE_EN defined, KA_CYCLES=100, no requests -> keep-alive word 64'h8001_0000_0000_0000 first presented 101 cycles after reset release, repeating every 100 cycles after each tx_last handshake.
